// File: rtl/sram_port_arbiter_pkg.sv
// Shared definitions for the base-SRAM port arbiter: FSM state encoding,
// default access length and reset polarity.
// No ports; imported by sram_port_arbiter and sram_access_timer.
package sram_port_arbiter_pkg;

    // Arbiter FSM states; the encoding is fixed so it can be probed from software-visible debug.
    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        INST_RD = 2'b01,
        DATA_RD = 2'b10,
        DATA_WR = 2'b11
    } state_t;

    // Extra SRAM cycles per access beyond the first.
    localparam int WAIT_CYCLES_DEF = 1;

    // Level of rst that resets the block.
    localparam logic RstEnable = 1'b1;

endpackage

// File: rtl/sram_access_timer.sv
// Access-length timer: counts cycles spent in an SRAM access and flags the last one.
// Ports: clk, rst (sync, active-high), busy (FSM is in an access state),
//        last (current cycle is the final cycle of the access).
module sram_access_timer
    import sram_port_arbiter_pkg::*;
#(
    parameter int WAIT_CYCLES = WAIT_CYCLES_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic busy,
    output logic last
);

    logic [2:0] cnt;

    // Counter sits at 0 whenever idle, so the first access cycle always reads 0.
    always_ff @(posedge clk) begin
        if (rst == RstEnable) begin
            cnt <= 3'd0;
        end else if (!busy || last) begin
            cnt <= 3'd0;
        end else begin
            cnt <= cnt + 3'd1;
        end
    end

    assign last = busy && (cnt == 3'(WAIT_CYCLES));

endmodule

// File: rtl/sram_port_arbiter.sv
// Arbiter sequencing one shared SRAM between the instruction (ICache refill)
// and data (MEM-stage) ports; one access at a time, registered SRAM pins,
// read data returned with a one-cycle valid pulse.
// Ports: clk/rst; inst_* request/response/stop; data_* request/response/stop;
//        sram_* pins (active-low controls, registered).
// Build option: define SRAM_RR_ARB_EN for round-robin arbitration when both
// ports request together; otherwise data always wins.
module sram_port_arbiter
    import sram_port_arbiter_pkg::*;
#(
    parameter int ADDR_W      = 20,
    parameter int WAIT_CYCLES = WAIT_CYCLES_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              inst_req,
    input  logic [31:0]       inst_addr,
    output logic [31:0]       inst_rdata,
    output logic              inst_valid,
    output logic              inst_stop,
    input  logic              data_req,
    input  logic              data_we,
    input  logic [3:0]        data_be,
    input  logic [31:0]       data_addr,
    input  logic [31:0]       data_wdata,
    output logic [31:0]       data_rdata,
    output logic              data_valid,
    output logic              data_stop,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [31:0]       sram_wdata,
    output logic              sram_wdata_oe,
    input  logic [31:0]       sram_rdata,
    output logic              sram_ce_n,
    output logic              sram_oe_n,
    output logic              sram_we_n,
    output logic [3:0]        sram_be_n
);

    state_t state, next_state;
    logic   grant_inst, grant_data;
    logic   last;

`ifdef SRAM_RR_ARB_EN
    // 1 = instruction has priority on the next contested cycle (last winner was data).
    logic last_grant;
`endif

    // A port still waiting is exactly a port that must be stopped; a request
    // whose valid is high is the one just completed and is not re-arbitrated.
    assign inst_stop = inst_req & ~inst_valid;
    assign data_stop = data_req & ~data_valid;

    sram_access_timer #(
        .WAIT_CYCLES(WAIT_CYCLES)
    ) u_timer (
        .clk  (clk),
        .rst  (rst),
        .busy (state != IDLE),
        .last (last)
    );

    always_ff @(posedge clk) begin
        if (rst == RstEnable) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        grant_inst = 1'b0;
        grant_data = 1'b0;
        case (state)
            IDLE: begin
`ifdef SRAM_RR_ARB_EN
                if (data_stop && inst_stop) begin
                    grant_inst = last_grant;
                    grant_data = ~last_grant;
                end else begin
                    grant_data = data_stop;
                    grant_inst = inst_stop;
                end
`else
                grant_data = data_stop;
                grant_inst = inst_stop & ~data_stop;
`endif
                if (grant_data) begin
                    next_state = data_we ? DATA_WR : DATA_RD;
                end else if (grant_inst) begin
                    next_state = INST_RD;
                end
            end
            default: begin
                if (last) begin
                    next_state = IDLE;
                end
            end
        endcase
    end

`ifdef SRAM_RR_ARB_EN
    always_ff @(posedge clk) begin
        if (rst == RstEnable) begin
            last_grant <= 1'b0;
        end else if (grant_data || grant_inst) begin
            last_grant <= grant_data;
        end
    end
`endif

    // SRAM pins are loaded at the grant edge and held until the final access
    // edge, where read data is captured and the completion pulse is raised.
    always_ff @(posedge clk) begin
        if (rst == RstEnable) begin
            sram_addr     <= '0;
            sram_wdata    <= 32'd0;
            sram_wdata_oe <= 1'b0;
            sram_ce_n     <= 1'b1;
            sram_oe_n     <= 1'b1;
            sram_we_n     <= 1'b1;
            sram_be_n     <= 4'hF;
            inst_rdata    <= 32'd0;
            data_rdata    <= 32'd0;
            inst_valid    <= 1'b0;
            data_valid    <= 1'b0;
        end else begin
            inst_valid <= 1'b0;
            data_valid <= 1'b0;
            if (state == IDLE) begin
                if (grant_data) begin
                    sram_addr <= data_addr[ADDR_W+1:2];
                    sram_ce_n <= 1'b0;
                    if (data_we) begin
                        sram_we_n     <= 1'b0;
                        sram_be_n     <= ~data_be;
                        sram_wdata    <= data_wdata;
                        sram_wdata_oe <= 1'b1;
                    end else begin
                        sram_oe_n <= 1'b0;
                        sram_be_n <= 4'h0;
                    end
                end else if (grant_inst) begin
                    sram_addr <= inst_addr[ADDR_W+1:2];
                    sram_ce_n <= 1'b0;
                    sram_oe_n <= 1'b0;
                    sram_be_n <= 4'h0;
                end
            end else if (last) begin
                sram_ce_n     <= 1'b1;
                sram_oe_n     <= 1'b1;
                sram_we_n     <= 1'b1;
                sram_be_n     <= 4'hF;
                sram_wdata_oe <= 1'b0;
                case (state)
                    INST_RD: begin
                        inst_rdata <= sram_rdata;
                        inst_valid <= 1'b1;
                    end
                    DATA_RD: begin
                        data_rdata <= sram_rdata;
                        data_valid <= 1'b1;
                    end
                    default: begin
                        data_valid <= 1'b1;
                    end
                endcase
            end
        end
    end

    // Byte-offset and out-of-range address bits carry no information for a word SRAM.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{inst_addr[31:ADDR_W+2], inst_addr[1:0],
                                data_addr[31:ADDR_W+2], data_addr[1:0]};

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Directed bench for sram_port_arbiter with WAIT_CYCLES=1 (access = 2 cycles,
// valid 3 cycles after the request is first seen in IDLE).
// Inputs change 1ns after a rising edge; outputs are checked on the falling edge.
module tb_sram_port_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic [31:0] inst_rdata;
    logic        inst_valid;
    logic        inst_stop;
    logic        data_req;
    logic        data_we;
    logic [3:0]  data_be;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic [31:0] data_rdata;
    logic        data_valid;
    logic        data_stop;
    logic [19:0] sram_addr;
    logic [31:0] sram_wdata;
    logic        sram_wdata_oe;
    logic [31:0] sram_rdata;
    logic        sram_ce_n;
    logic        sram_oe_n;
    logic        sram_we_n;
    logic [3:0]  sram_be_n;

    int tests_run = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    sram_port_arbiter #(
        .ADDR_W(20),
        .WAIT_CYCLES(1)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .inst_req      (inst_req),
        .inst_addr     (inst_addr),
        .inst_rdata    (inst_rdata),
        .inst_valid    (inst_valid),
        .inst_stop     (inst_stop),
        .data_req      (data_req),
        .data_we       (data_we),
        .data_be       (data_be),
        .data_addr     (data_addr),
        .data_wdata    (data_wdata),
        .data_rdata    (data_rdata),
        .data_valid    (data_valid),
        .data_stop     (data_stop),
        .sram_addr     (sram_addr),
        .sram_wdata    (sram_wdata),
        .sram_wdata_oe (sram_wdata_oe),
        .sram_rdata    (sram_rdata),
        .sram_ce_n     (sram_ce_n),
        .sram_oe_n     (sram_oe_n),
        .sram_we_n     (sram_we_n),
        .sram_be_n     (sram_be_n)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    initial begin
        rst        = 1'b1;
        inst_req   = 1'b0;
        inst_addr  = 32'd0;
        data_req   = 1'b0;
        data_we    = 1'b0;
        data_be    = 4'h0;
        data_addr  = 32'd0;
        data_wdata = 32'd0;
        sram_rdata = 32'd0;

        // ---------------- reset state ----------------
        next_cycle();
        next_cycle();
        sample();
        check_eq("rst_ce_n", 32'(sram_ce_n), 32'd1);
        check_eq("rst_oe_n", 32'(sram_oe_n), 32'd1);
        check_eq("rst_we_n", 32'(sram_we_n), 32'd1);
        check_eq("rst_be_n", 32'(sram_be_n), 32'hF);
        check_eq("rst_wdata_oe", 32'(sram_wdata_oe), 32'd0);
        check_eq("rst_addr", 32'(sram_addr), 32'd0);
        check_eq("rst_wdata", sram_wdata, 32'd0);
        check_eq("rst_valids", {30'd0, inst_valid, data_valid}, 32'd0);
        check_eq("rst_inst_rdata", inst_rdata, 32'd0);
        check_eq("rst_data_rdata", data_rdata, 32'd0);
        next_cycle();
        rst = 1'b0;

        // ---------------- instruction read ----------------
        next_cycle();
        inst_req   = 1'b1;
        inst_addr  = 32'h0000_0100;
        sram_rdata = 32'h2408_0001;
        sample();
        check_eq("ird_c0_stop", 32'(inst_stop), 32'd1);
        check_eq("ird_c0_ce_n", 32'(sram_ce_n), 32'd1);
        for (int c = 1; c <= 2; c++) begin
            next_cycle();
            sample();
            check_eq("ird_addr", 32'(sram_addr), 32'h40);
            check_eq("ird_ce_n", 32'(sram_ce_n), 32'd0);
            check_eq("ird_oe_n", 32'(sram_oe_n), 32'd0);
            check_eq("ird_be_n", 32'(sram_be_n), 32'h0);
            check_eq("ird_stop", 32'(inst_stop), 32'd1);
            check_eq("ird_valid_early", 32'(inst_valid), 32'd0);
        end
        next_cycle();
        sample();
        check_eq("ird_c3_valid", 32'(inst_valid), 32'd1);
        check_eq("ird_c3_rdata", inst_rdata, 32'h2408_0001);
        check_eq("ird_c3_stop", 32'(inst_stop), 32'd0);
        check_eq("ird_c3_ce_n", 32'(sram_ce_n), 32'd1);
        next_cycle();
        inst_req = 1'b0;
        sram_rdata = 32'h0;
        sample();
        check_eq("ird_c4_valid", 32'(inst_valid), 32'd0);
        check_eq("ird_c4_rdata_kept", inst_rdata, 32'h2408_0001);

        // ---------------- data write ----------------
        next_cycle();
        data_req   = 1'b1;
        data_we    = 1'b1;
        data_be    = 4'b0011;
        data_addr  = 32'h0000_0204;
        data_wdata = 32'hDEAD_BEEF;
        sample();
        check_eq("dwr_c0_stop", 32'(data_stop), 32'd1);
        for (int c = 1; c <= 2; c++) begin
            next_cycle();
            sample();
            check_eq("dwr_addr", 32'(sram_addr), 32'h81);
            check_eq("dwr_be_n", 32'(sram_be_n), 32'hC);
            check_eq("dwr_we_n", 32'(sram_we_n), 32'd0);
            check_eq("dwr_oe_n", 32'(sram_oe_n), 32'd1);
            check_eq("dwr_ce_n", 32'(sram_ce_n), 32'd0);
            check_eq("dwr_wdata_oe", 32'(sram_wdata_oe), 32'd1);
            check_eq("dwr_wdata", sram_wdata, 32'hDEAD_BEEF);
        end
        next_cycle();
        sample();
        check_eq("dwr_c3_valid", 32'(data_valid), 32'd1);
        check_eq("dwr_c3_we_n", 32'(sram_we_n), 32'd1);
        check_eq("dwr_c3_wdata_oe", 32'(sram_wdata_oe), 32'd0);
        next_cycle();
        data_req = 1'b0;
        data_we  = 1'b0;
        sample();
        check_eq("dwr_c4_valid", 32'(data_valid), 32'd0);

        // ---------------- simultaneous requests ----------------
        next_cycle();
        inst_req   = 1'b1;
        inst_addr  = 32'h0000_0100;
        data_req   = 1'b1;
        data_we    = 1'b0;
        data_addr  = 32'h0000_0208;
        sram_rdata = 32'h1111_2222;
        sample();
        for (int c = 1; c <= 2; c++) begin
            next_cycle();
            sample();
            check_eq("both_data_addr", 32'(sram_addr), 32'h82);
            check_eq("both_data_oe_n", 32'(sram_oe_n), 32'd0);
            check_eq("both_inst_stop", 32'(inst_stop), 32'd1);
        end
        next_cycle();
        sample();
        check_eq("both_c3_dvalid", 32'(data_valid), 32'd1);
        check_eq("both_c3_drdata", data_rdata, 32'h1111_2222);
        check_eq("both_c3_inst_stop", 32'(inst_stop), 32'd1);
        check_eq("both_c3_ivalid", 32'(inst_valid), 32'd0);
        next_cycle();
        data_req   = 1'b0;
        sram_rdata = 32'h3333_4444;
        sample();
        check_eq("both_c4_inst_addr", 32'(sram_addr), 32'h40);
        check_eq("both_c4_ce_n", 32'(sram_ce_n), 32'd0);
        check_eq("both_c4_dvalid", 32'(data_valid), 32'd0);
        next_cycle();
        sample();
        check_eq("both_c5_ivalid", 32'(inst_valid), 32'd0);
        next_cycle();
        sample();
        check_eq("both_c6_ivalid", 32'(inst_valid), 32'd1);
        check_eq("both_c6_irdata", inst_rdata, 32'h3333_4444);
        check_eq("both_c6_dvalid", 32'(data_valid), 32'd0);
        next_cycle();
        inst_req = 1'b0;
        sample();
        check_eq("both_c7_ivalid", 32'(inst_valid), 32'd0);

        // ---------------- back-to-back instruction reads ----------------
        next_cycle();
        inst_req   = 1'b1;
        inst_addr  = 32'h0000_0100;
        sram_rdata = 32'hAAAA_0100;
        sample();
        next_cycle();
        sample();
        check_eq("b2b_c1_addr", 32'(sram_addr), 32'h40);
        next_cycle();
        sample();
        next_cycle();
        sample();
        check_eq("b2b_c3_valid", 32'(inst_valid), 32'd1);
        check_eq("b2b_c3_ce_n", 32'(sram_ce_n), 32'd1);
        next_cycle();
        inst_addr  = 32'h0000_0104;
        sram_rdata = 32'hAAAA_0104;
        sample();
        check_eq("b2b_c4_no_dup_ce_n", 32'(sram_ce_n), 32'd1);
        check_eq("b2b_c4_valid", 32'(inst_valid), 32'd0);
        for (int c = 5; c <= 6; c++) begin
            next_cycle();
            sample();
            check_eq("b2b_second_addr", 32'(sram_addr), 32'h41);
            check_eq("b2b_second_ce_n", 32'(sram_ce_n), 32'd0);
        end
        next_cycle();
        sample();
        check_eq("b2b_c7_valid", 32'(inst_valid), 32'd1);
        check_eq("b2b_c7_rdata", inst_rdata, 32'hAAAA_0104);
        next_cycle();
        inst_req = 1'b0;
        sample();

        // ---------------- reset in the middle of a write ----------------
        next_cycle();
        data_req   = 1'b1;
        data_we    = 1'b1;
        data_be    = 4'hF;
        data_addr  = 32'h0000_0300;
        data_wdata = 32'h1234_5678;
        sample();
        next_cycle();
        sample();
        check_eq("rstw_c1_we_n", 32'(sram_we_n), 32'd0);
        next_cycle();
        rst = 1'b1;
        sample();
        next_cycle();
        rst = 1'b0;
        sample();
        check_eq("rstw_c3_we_n", 32'(sram_we_n), 32'd1);
        check_eq("rstw_c3_ce_n", 32'(sram_ce_n), 32'd1);
        check_eq("rstw_c3_dvalid", 32'(data_valid), 32'd0);
        check_eq("rstw_c3_dstop", 32'(data_stop), 32'd1);
        for (int c = 4; c <= 5; c++) begin
            next_cycle();
            sample();
            check_eq("rstw_regrant_addr", 32'(sram_addr), 32'hC0);
            check_eq("rstw_regrant_we_n", 32'(sram_we_n), 32'd0);
            check_eq("rstw_regrant_dvalid", 32'(data_valid), 32'd0);
        end
        next_cycle();
        sample();
        check_eq("rstw_c6_dvalid", 32'(data_valid), 32'd1);
        next_cycle();
        data_req = 1'b0;
        data_we  = 1'b0;
        sample();

        // ---------------- both ports requesting continuously ----------------
        // Period 2*(WAIT_CYCLES+2)=6: data access c1-2, valid c3; inst access c4-5, valid c6.
        next_cycle();
        inst_req   = 1'b1;
        inst_addr  = 32'h0000_0100;
        data_req   = 1'b1;
        data_we    = 1'b0;
        data_addr  = 32'h0000_0200;
        sram_rdata = 32'hA5A5_0000;
        sample();
        for (int c = 1; c <= 18; c++) begin
            next_cycle();
            sample();
            check_eq("alt_dvalid", 32'(data_valid), 32'((c % 6) == 3));
            check_eq("alt_ivalid", 32'(inst_valid), 32'((c % 6) == 0));
            if ((c % 6) == 1 || (c % 6) == 2) begin
                check_eq("alt_data_addr", 32'(sram_addr), 32'h80);
            end else if ((c % 6) == 4 || (c % 6) == 5) begin
                check_eq("alt_inst_addr", 32'(sram_addr), 32'h40);
            end else begin
                check_eq("alt_idle_ce_n", 32'(sram_ce_n), 32'd1);
            end
        end
        next_cycle();
        inst_req = 1'b0;
        data_req = 1'b0;
        sample();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
